bno055_burst_sequencer: RTL and testbench
=========================================

// Module: bno055_burst_sequencer
// PURPOSE
//  Parametrised successor to the single-register BNO055 bring-up FSM. After reset it waits for
//  sensor boot, writes OPR_MODE, and verifies the write by readback. It then polls a contiguous
//  block of NUM_REGS registers at a fixed rate, e.g. Euler heading/roll/pitch at 0x1A..0x1F.
//  Sits between the board top and bno055_read_write; adds per-op timeout, retry and an atomic data frame.
// PARAMETERS
//  NUM_REGS      6        bytes per burst, 1..32
//  START_ADDR    8'h1A    first register of burst
//  MODE_ADDR     8'h3D    OPR_MODE register address
//  MODE_VAL      8'h0C    value written to MODE_ADDR (NDOF)
//  BOOT_CYC      16250000 cycles after reset before first op (650 ms @25 MHz)
//  MODE_CYC      500000   cycles after mode write before readback (20 ms)
//  POLL_CYC      250000   cycles from burst start to next burst start (100 Hz)
//  TIMEOUT_CYC   250000   max cycles from op issue to i_done
//  MAX_RETRY     3        retries per op before error
// PORTS
//  i_clk       in   1            system clock
//  i_rst       in   1            synchronous, active-high reset
//  i_poll_en   in   1            1 = keep polling; 0 = hold after current burst
//  o_opcode    out  2            to bno055_read_write: STOP=0 READ=1 WRITE=2
//  o_reg_addr  out  8            register address of current op
//  o_tx_data   out  8            write data (MODE_VAL)
//  i_rd_data   in   8            read data from engine, valid with i_done
//  i_done      in   1            one-cycle op-complete strobe
//  o_data      out  8*NUM_REGS   last complete frame; byte k = reg START_ADDR+k at [8k+7:8k]
//  o_valid     out  1            one-cycle pulse when o_data updates
//  o_cfg_ok    out  1            high once readback == MODE_VAL
//  o_error     out  1            sticky fault, cleared only by i_rst
// BEHAVIOUR
//  Reset: state=BOOT_WAIT, o_opcode=STOP, o_reg_addr=0, o_tx_data=0, o_data=0, o_valid=0,
//   o_cfg_ok=0, o_error=0, byte index=0, retry=0, timer loaded BOOT_CYC.
//  Reset mid-op: the same reset applies; the engine shares i_rst, so no bus recovery happens here.
//  Opcode rule: o_opcode is non-STOP for exactly one cycle per op (the ISSUE state), then STOP.
//   o_reg_addr and o_tx_data are driven in that cycle and held until the next ISSUE.
//  FSM:
//   BOOT_WAIT   timer==0 -> CFG_ISSUE
//   CFG_ISSUE   WRITE MODE_ADDR/MODE_VAL, timer=TIMEOUT_CYC -> CFG_WAIT
//   CFG_WAIT    i_done -> MODE_DLY (timer=MODE_CYC); timeout -> RETRY
//   MODE_DLY    timer==0 -> VFY_ISSUE
//   VFY_ISSUE   READ MODE_ADDR -> VFY_WAIT
//   VFY_WAIT    i_done & rd==MODE_VAL -> o_cfg_ok=1, retry=0, BURST_ISSUE;
//               i_done & mismatch or timeout -> RETRY (re-enter CFG_ISSUE)
//   BURST_ISSUE READ START_ADDR+idx; on idx==0 load poll counter with POLL_CYC -> BURST_WAIT
//   BURST_WAIT  i_done: stage[idx]<=i_rd_data; idx==NUM_REGS-1 -> PUBLISH, else idx++ -> BURST_ISSUE;
//               timeout -> RETRY (restart same byte; staged bytes kept)
//   PUBLISH     o_data<=stage, o_valid=1 for 1 cycle, idx=0, retry=0 -> POLL_WAIT
//   POLL_WAIT   poll counter==0 & i_poll_en -> BURST_ISSUE; i_poll_en=0 -> hold
//   RETRY       retry==MAX_RETRY -> ERROR, else retry++ and return to the failed phase's ISSUE state
//   ERROR       o_error=1, opcode STOP, terminal until reset
//  Poll counter is free-running from burst start; if a burst overruns POLL_CYC, next burst starts
//   immediately after PUBLISH (no catch-up bursts).
//  o_data changes only in PUBLISH, never torn; o_data holds the last frame through retries and ERROR.
//  Address = START_ADDR+idx, mod 256.
//  i_done outside *_WAIT states is ignored. If i_done and timeout occur in the same cycle, i_done wins.
//  Timeout = timer reaches 0 while in *_WAIT. Retry counter is reset on every successful op.
//  Widths: timers use $clog2(max cycle param + 1) bits; idx uses $clog2(NUM_REGS) bits (min 1).
// STRUCTURE
//  bno055_pkg: OP_STOP/OP_READ/OP_WRITE, BNO055 register addresses (CHIP_ID, OPR_MODE, EUL_DATA,
//   QUA_DATA), mode values, state encodings.
//  Sub-module bno055_cycle_timer: loadable down-counter with zero flag, shared by boot, mode, timeout.
//   A second instance serves as the poll counter.
// TESTING (bench: behavioural engine model with configurable latency and per-op fault injection)
//  1 Reset, BOOT_CYC=10: first WRITE exactly 11 cycles after reset release, addr 0x3D, data 0x0C, 1-cycle pulse.
//  2 Readback 0x0C -> o_cfg_ok=1; model returns 0x10+k for addr 0x1A+k ->
//    o_valid pulse, o_data=48'h15_14_13_12_11_10.
//  3 Readback 0x08 three times, then 0x0C -> three rewrites, cfg_ok set, no error;
//    four mismatches with MAX_RETRY=3 -> o_error=1, opcode stays STOP.
//  4 Drop i_done on byte 3 once -> timeout after TIMEOUT_CYC, 0x1D reread, frame correct;
//    o_data holds old frame until PUBLISH.
//  5 POLL_CYC=100, latency 5: burst starts every 100 cycles; i_poll_en=0 mid-burst ->
//    burst completes, publishes, then stalls; reasserting resumes.
//  6 Assert i_rst during BURST_WAIT with idx=2 -> all outputs at reset values next cycle,
//    sequence restarts at BOOT_WAIT.

Source files
------------

// File: rtl/bno055_pkg.sv
// Shared constants for the BNO055 bring-up and burst-polling logic.
//  - engine opcodes understood by bno055_read_write
//  - BNO055 register addresses and operating-mode values
//  - FSM state encodings for bno055_burst_sequencer
//  - small width helpers used when sizing counters
package bno055_pkg;

    // Engine opcodes
    localparam logic [1:0] OP_STOP  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    // Register map (page 0)
    localparam logic [7:0] REG_CHIP_ID  = 8'h00;
    localparam logic [7:0] REG_EUL_DATA = 8'h1A;
    localparam logic [7:0] REG_QUA_DATA = 8'h20;
    localparam logic [7:0] REG_OPR_MODE = 8'h3D;

    // OPR_MODE values
    localparam logic [7:0] MODE_CONFIG = 8'h00;
    localparam logic [7:0] MODE_IMU    = 8'h08;
    localparam logic [7:0] MODE_NDOF   = 8'h0C;

    // Sequencer states
    localparam logic [3:0] ST_BOOT_WAIT   = 4'd0;
    localparam logic [3:0] ST_CFG_ISSUE   = 4'd1;
    localparam logic [3:0] ST_CFG_WAIT    = 4'd2;
    localparam logic [3:0] ST_MODE_DLY    = 4'd3;
    localparam logic [3:0] ST_VFY_ISSUE   = 4'd4;
    localparam logic [3:0] ST_VFY_WAIT    = 4'd5;
    localparam logic [3:0] ST_BURST_ISSUE = 4'd6;
    localparam logic [3:0] ST_BURST_WAIT  = 4'd7;
    localparam logic [3:0] ST_PUBLISH     = 4'd8;
    localparam logic [3:0] ST_POLL_WAIT   = 4'd9;
    localparam logic [3:0] ST_RETRY       = 4'd10;
    localparam logic [3:0] ST_ERROR       = 4'd11;

    // Bits needed to index v items; never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bno055_cycle_timer.sv
// Loadable down-counter with a zero flag. Counts toward zero and parks
// there; a load takes priority over counting.
//  clk, rst   clock, synchronous active-high reset (loads RST_VAL)
//  load       load load_val this cycle
//  load_val   value to load
//  zero       counter currently equals zero
module bno055_cycle_timer #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/bno055_burst_sequencer.sv
// BNO055 bring-up and burst poller. Waits for sensor boot, writes OPR_MODE,
// verifies it by readback, then reads NUM_REGS consecutive registers at a
// fixed rate and publishes them as one atomic frame. Every op has a timeout
// and bounded retries; exhausting retries lands in a sticky error state.
//  i_clk, i_rst  clock, synchronous active-high reset
//  i_poll_en     keep polling; low holds after the current burst
//  o_opcode      engine opcode, non-STOP for exactly the ISSUE cycle
//  o_reg_addr    register address of the current op (held between ops)
//  o_tx_data     write data (held between ops)
//  i_rd_data     engine read data, valid with i_done
//  i_done        one-cycle op-complete strobe
//  o_data        last complete frame, byte k = register START_ADDR+k
//  o_valid       one-cycle pulse when o_data updates
//  o_cfg_ok      mode readback matched
//  o_error       sticky fault
module bno055_burst_sequencer
    import bno055_pkg::*;
#(
    parameter int         NUM_REGS    = 6,
    parameter logic [7:0] START_ADDR  = REG_EUL_DATA,
    parameter logic [7:0] MODE_ADDR   = REG_OPR_MODE,
    parameter logic [7:0] MODE_VAL    = MODE_NDOF,
    parameter int         BOOT_CYC    = 16250000,
    parameter int         MODE_CYC    = 500000,
    parameter int         POLL_CYC    = 250000,
    parameter int         TIMEOUT_CYC = 250000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_poll_en,
    output logic [1:0]            o_opcode,
    output logic [7:0]            o_reg_addr,
    output logic [7:0]            o_tx_data,
    input  logic [7:0]            i_rd_data,
    input  logic                  i_done,
    output logic [8*NUM_REGS-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_cfg_ok,
    output logic                  o_error
);

    localparam int IDX_W = clog2_min1(NUM_REGS);
    localparam int RTY_W = clog2_min1(MAX_RETRY + 1);
    localparam int TMR_W = $clog2(max3(BOOT_CYC, MODE_CYC, TIMEOUT_CYC) + 1);
    localparam int PLL_W = $clog2(POLL_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

    logic [3:0]                state, state_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    logic [RTY_W-1:0]          retry, retry_nxt;
    logic                      phase_burst, phase_nxt;   // which ISSUE a retry returns to
    logic                      tmr_load, tmr_zero;
    logic [TMR_W-1:0]          tmr_val;
    logic                      poll_load, poll_zero;
    logic                      stage_wr, cfg_ok_set, publish, err_set;
    logic [NUM_REGS-1:0][7:0]  stage;

    bno055_cycle_timer #(.W(TMR_W), .RST_VAL(TMR_W'(BOOT_CYC))) u_tmr (
        .clk(i_clk), .rst(i_rst), .load(tmr_load), .load_val(tmr_val), .zero(tmr_zero)
    );

    // Loaded on entry to the first byte's ISSUE with POLL_CYC-1 so that the
    // next burst's ISSUE cycle lands exactly POLL_CYC cycles after this one.
    bno055_cycle_timer #(.W(PLL_W), .RST_VAL('0)) u_poll (
        .clk(i_clk), .rst(i_rst), .load(poll_load), .load_val(PLL_W'(POLL_CYC - 1)),
        .zero(poll_zero)
    );

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        retry_nxt  = retry;
        phase_nxt  = phase_burst;
        tmr_load   = 1'b0;
        tmr_val    = TMR_W'(TIMEOUT_CYC);
        stage_wr   = 1'b0;
        cfg_ok_set = 1'b0;
        publish    = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_BOOT_WAIT: if (tmr_zero) state_nxt = ST_CFG_ISSUE;
            ST_CFG_ISSUE: begin
                tmr_load  = 1'b1;
                phase_nxt = 1'b0;
                state_nxt = ST_CFG_WAIT;
            end
            ST_CFG_WAIT: begin
                // A completed write does not clear retry: the config op is
                // the write plus its readback, so only a good readback does.
                if (i_done) begin
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(MODE_CYC);
                    state_nxt = ST_MODE_DLY;
                end else if (tmr_zero) begin
                    state_nxt = ST_RETRY;
                end
            end
            ST_MODE_DLY: if (tmr_zero) state_nxt = ST_VFY_ISSUE;
            ST_VFY_ISSUE: begin
                tmr_load  = 1'b1;
                state_nxt = ST_VFY_WAIT;
            end
            ST_VFY_WAIT: begin
                if (i_done && i_rd_data == MODE_VAL) begin
                    cfg_ok_set = 1'b1;
                    retry_nxt  = '0;
                    idx_nxt    = '0;
                    state_nxt  = ST_BURST_ISSUE;
                end else if (i_done || tmr_zero) begin
                    state_nxt = ST_RETRY;
                end
            end
            ST_BURST_ISSUE: begin
                tmr_load  = 1'b1;
                phase_nxt = 1'b1;
                state_nxt = ST_BURST_WAIT;
            end
            ST_BURST_WAIT: begin
                if (i_done) begin
                    stage_wr  = 1'b1;
                    retry_nxt = '0;
                    if (idx == IDX_LAST) begin
                        state_nxt = ST_PUBLISH;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = ST_BURST_ISSUE;
                    end
                end else if (tmr_zero) begin
                    state_nxt = ST_RETRY;     // idx kept: same byte is reread
                end
            end
            ST_PUBLISH: begin
                publish   = 1'b1;
                idx_nxt   = '0;
                retry_nxt = '0;
                state_nxt = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: if (poll_zero && i_poll_en) state_nxt = ST_BURST_ISSUE;
            ST_RETRY: begin
                if (retry == RTY_W'(MAX_RETRY)) begin
                    err_set   = 1'b1;
                    state_nxt = ST_ERROR;
                end else begin
                    retry_nxt = retry + 1'b1;
                    state_nxt = phase_burst ? ST_BURST_ISSUE : ST_CFG_ISSUE;
                end
            end
            ST_ERROR: state_nxt = ST_ERROR;
            default:  state_nxt = ST_BOOT_WAIT;
        endcase
    end

    assign poll_load = (state_nxt == ST_BURST_ISSUE) && (idx_nxt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_BOOT_WAIT;
            idx         <= '0;
            retry       <= '0;
            phase_burst <= 1'b0;
            stage       <= '0;
            o_opcode    <= OP_STOP;
            o_reg_addr  <= '0;
            o_tx_data   <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_cfg_ok    <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            retry       <= retry_nxt;
            phase_burst <= phase_nxt;
            o_valid     <= publish;
            if (stage_wr)   stage[idx] <= i_rd_data;
            if (publish)    o_data     <= stage;
            if (cfg_ok_set) o_cfg_ok   <= 1'b1;
            if (err_set)    o_error    <= 1'b1;
            // Opcode is registered from the next state, so it is non-STOP
            // exactly while the FSM sits in an ISSUE state.
            case (state_nxt)
                ST_CFG_ISSUE: begin
                    o_opcode   <= OP_WRITE;
                    o_reg_addr <= MODE_ADDR;
                    o_tx_data  <= MODE_VAL;
                end
                ST_VFY_ISSUE: begin
                    o_opcode   <= OP_READ;
                    o_reg_addr <= MODE_ADDR;
                end
                ST_BURST_ISSUE: begin
                    o_opcode   <= OP_READ;
                    o_reg_addr <= START_ADDR + 8'(idx_nxt);   // wraps mod 256
                end
                default: o_opcode <= OP_STOP;
            endcase
        end
    end

endmodule

// File: tb/tb_bno055_burst_sequencer.sv
// Bench for bno055_burst_sequencer: behavioural engine model with
// configurable latency, readback and drop injection, plus a frame scoreboard.
module tb_bno055_burst_sequencer;

    localparam int         NR    = 6;
    localparam int         TMO   = 30;
    localparam logic [7:0] SADDR = 8'h1A;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            poll_en = 1'b1;
    logic            done = 1'b0;
    logic [7:0]      rd_data = 8'h00;
    logic [1:0]      opcode;
    logic [7:0]      reg_addr, tx_data;
    logic [8*NR-1:0] data;
    logic            valid, cfg_ok, error;

    always #5 clk = ~clk;

    bno055_burst_sequencer #(
        .NUM_REGS(NR), .START_ADDR(SADDR), .MODE_ADDR(8'h3D), .MODE_VAL(8'h0C),
        .BOOT_CYC(10), .MODE_CYC(20), .POLL_CYC(100), .TIMEOUT_CYC(TMO), .MAX_RETRY(3)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_poll_en(poll_en),
        .o_opcode(opcode), .o_reg_addr(reg_addr), .o_tx_data(tx_data),
        .i_rd_data(rd_data), .i_done(done),
        .o_data(data), .o_valid(valid), .o_cfg_ok(cfg_ok), .o_error(error)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_chk++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
        end
    endtask

    // ---------------- engine model / stimulus state ----------------
    int              cyc = 0;
    int              lat = 5;
    logic [7:0]      byte_base = 8'h10;
    logic [7:0]      drop_addr = 8'h00;
    int              drop_cnt = 0;
    logic [7:0]      vfy_q[$];
    logic [8*NR-1:0] sb_q[$];
    int              starts[$];
    int              wr_cnt = 0, rd1d = 0, hit_idx2 = 0, pub_cnt = 0;
    int              t1d_prev = 0, t1d_last = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : engine
        logic       busy, drop_now;
        logic [1:0] cur_op;
        logic [7:0] cur_addr, resp;
        logic [7:0] mdl [NR];
        logic [8*NR-1:0] frame;
        int lat_cnt, k;
        busy = 1'b0;
        drop_now = 1'b0;
        lat_cnt = 0;
        resp = 8'h00;
        for (int j = 0; j < NR; j++) mdl[j] = 8'h00;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else if (busy) begin
                if (lat_cnt == 0) begin
                    busy = 1'b0;
                    if (!drop_now) begin
                        done = 1'b1;
                        rd_data = resp;
                        if (cur_op == 2'd1 && cur_addr != 8'h3D) begin
                            k = int'(cur_addr) - int'(SADDR);
                            mdl[k] = resp;
                            if (k == NR - 1) begin
                                for (int j = 0; j < NR; j++) frame[8*j +: 8] = mdl[j];
                                sb_q.push_back(frame);
                            end
                        end
                    end
                end else begin
                    lat_cnt--;
                end
            end else if (opcode != 2'd0) begin
                busy = 1'b1;
                lat_cnt = lat - 1;
                cur_op = opcode;
                cur_addr = reg_addr;
                drop_now = 1'b0;
                resp = 8'h00;
                if (opcode == 2'd2) begin
                    wr_cnt++;
                    chk("wr_addr", reg_addr, 8'h3D);
                    chk("wr_data", tx_data, 8'h0C);
                end else if (reg_addr == 8'h3D) begin
                    resp = (vfy_q.size() > 0) ? vfy_q.pop_front() : 8'h0C;
                end else begin
                    k = int'(reg_addr) - int'(SADDR);
                    chk("rd_range", (k >= 0 && k < NR), 1);
                    resp = byte_base + 8'(k);
                    if (reg_addr == SADDR) starts.push_back(cyc);
                    if (reg_addr == 8'h1C) hit_idx2++;
                    if (reg_addr == 8'h1D) begin
                        rd1d++;
                        t1d_prev = t1d_last;
                        t1d_last = cyc;
                    end
                    if (reg_addr == drop_addr && drop_cnt > 0) begin
                        drop_now = 1'b1;
                        drop_cnt--;
                    end
                end
            end
        end
    end

    // Output monitor: opcode pulse width, o_valid pulse width, frame scoreboard.
    initial begin : monitor
        logic prev_nz, prev_v;
        logic [8*NR-1:0] exp_f;
        prev_nz = 1'b0;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_nz = 1'b0;
                prev_v = 1'b0;
            end else begin
                if (opcode != 2'd0) chk("op_pulse", prev_nz, 1'b0);
                prev_nz = (opcode != 2'd0);
                if (valid) begin
                    chk("valid_pulse", prev_v, 1'b0);
                    chk("sb_nonempty", (sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        exp_f = sb_q.pop_front();
                        chk("frame", data, exp_f);
                    end
                    pub_cnt++;
                end
                prev_v = valid;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk_reset_outs();
        chk("rst_opcode", opcode, 2'd0);
        chk("rst_addr", reg_addr, 8'h00);
        chk("rst_tx", tx_data, 8'h00);
        chk("rst_data", data, '0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_cfg_ok", cfg_ok, 1'b0);
        chk("rst_error", error, 1'b0);
    endtask

    // Called right after reset is released on a falling edge: the first
    // WRITE must appear after exactly 11 rising edges, for one cycle.
    task automatic check_boot();
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i <= 10) chk("boot_stop", opcode, 2'd0);
            if (i == 11) begin
                chk("boot_write", opcode, 2'd2);
                chk("boot_addr", reg_addr, 8'h3D);
                chk("boot_tx", tx_data, 8'h0C);
            end
            if (i == 12) chk("boot_pulse", opcode, 2'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1 chk_reset_outs();
        @(negedge clk);
        rst = 1'b0;
        check_boot();
    endtask

    task automatic wait_pub(input int n, input int max_cyc);
        int tgt, t;
        tgt = pub_cnt + n;
        t = 0;
        while (pub_cnt < tgt && t < max_cyc) begin
            @(negedge clk);
            #1 t++;
        end
        chk("wait_pub", (pub_cnt >= tgt), 1);
    endtask

    // ---------------- sequence ----------------
    initial begin
        int s0, p0, r0, t, nz;

        // Reset, boot timing, config, first frame
        do_reset();
        wait_pub(1, 300);
        chk("cfg_ok", cfg_ok, 1'b1);
        chk("frame0", data, 48'h15_14_13_12_11_10);
        chk("no_err", error, 1'b0);

        // Poll period with latency 5
        wait_pub(2, 300);
        chk("starts_n", (starts.size() >= 3), 1);
        chk("period0", starts[1] - starts[0], 100);
        chk("period1", starts[2] - starts[1], 100);

        // Drop i_poll_en mid-burst
        s0 = starts.size();
        t = 0;
        while (starts.size() == s0 && t < 150) begin @(negedge clk); #1 t++; end
        chk("burst_seen", (starts.size() > s0), 1);
        repeat (10) @(negedge clk);
        poll_en = 1'b0;
        p0 = pub_cnt;
        wait_pub(1, 100);
        repeat (300) @(negedge clk);
        chk("hold_starts", starts.size(), s0 + 1);
        chk("hold_pubs", pub_cnt, p0 + 1);
        poll_en = 1'b1;
        t = 0;
        while (starts.size() == s0 + 1 && t < 10) begin @(negedge clk); #1 t++; end
        chk("resume", (starts.size() > s0 + 1), 1);
        wait_pub(1, 100);

        // Drop i_done on byte 3 once, new frame values
        byte_base = 8'h40;
        drop_addr = 8'h1D;
        drop_cnt = 1;
        r0 = rd1d;
        t = 0;
        while (rd1d < r0 + 2 && t < 250) begin @(negedge clk); #1 t++; end
        chk("reread_1d", rd1d, r0 + 2);
        chk("tmo_gap", (t1d_last - t1d_prev >= TMO && t1d_last - t1d_prev <= TMO + 4), 1);
        chk("hold_old", data, 48'h15_14_13_12_11_10);
        wait_pub(1, 100);
        chk("frame_retry", data, 48'h45_44_43_42_41_40);
        chk("rd1d_total", rd1d, r0 + 2);
        chk("no_err2", error, 1'b0);

        // Reset during BURST_WAIT with idx=2
        s0 = hit_idx2;
        t = 0;
        while (hit_idx2 == s0 && t < 150) begin @(negedge clk); #1 t++; end
        chk("idx2_seen", (hit_idx2 > s0), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1 chk_reset_outs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_boot();
        wait_pub(1, 300);
        chk("frame_after_rst", data, 48'h45_44_43_42_41_40);

        // Three bad readbacks then good: recovers
        vfy_q = '{8'h08, 8'h08, 8'h08};
        wr_cnt = 0;
        do_reset();
        t = 0;
        while (!cfg_ok && t < 600) begin @(negedge clk); #1 t++; end
        chk("retry_cfg_ok", cfg_ok, 1'b1);
        chk("retry_writes", wr_cnt, 4);
        chk("retry_no_err", error, 1'b0);

        // Four bad readbacks: error, opcode parked at STOP
        vfy_q = '{8'h08, 8'h08, 8'h08, 8'h08};
        wr_cnt = 0;
        do_reset();
        t = 0;
        while (!error && t < 800) begin @(negedge clk); #1 t++; end
        chk("err_set", error, 1'b1);
        chk("err_writes", wr_cnt, 4);
        chk("err_cfg_ok", cfg_ok, 1'b0);
        nz = 0;
        repeat (50) begin
            @(negedge clk);
            if (opcode != 2'd0) nz++;
        end
        chk("err_stop", nz, 0);
        chk("err_sticky", error, 1'b1);
        chk("err_data", data, '0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
